// File: rtl/cmd_queue_arbiter_pkg.sv
// Shared types and constants for the command-queue write-port arbiter.
// The cmd_queue instance uses the same CMDQ_* constants so both sides agree on sizing.
package cmd_queue_arbiter_pkg;

    localparam int CMDQ_NUM_REQ = 2;
    localparam int CMDQ_DEPTH   = 16;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] addr;
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cmd_queue_arbiter_if.sv
// Bundle of per-source request handshakes plus the FIFO-side write, pop and status signals.
// Handshake: a beat moves when i_req_valid[i] & o_req_ready[i] on a rising edge; ready never looks at data.
interface cmd_queue_arbiter_if
    import cmd_queue_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CMDQ_NUM_REQ,
    parameter int DEPTH   = CMDQ_DEPTH
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int LW  = $clog2(DEPTH) + 1;

    logic [NUM_REQ-1:0]       i_req_valid;
    logic [NUM_REQ-1:0]       i_req_last;
    cmd_t [NUM_REQ-1:0]       i_req_data;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic                     i_fifo_read;
    logic                     o_fifo_write;
    cmd_t                     o_fifo_data;
    logic [LW-1:0]            o_level;
    logic                     o_full;
    logic [IDW-1:0]           o_grant_id;
    logic                     o_busy;

    modport master (
        output i_req_valid, i_req_last, i_req_data, i_fifo_read,
        input  o_req_ready, o_fifo_write, o_fifo_data, o_level, o_full, o_grant_id, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_last, i_req_data, i_fifo_read,
        output o_req_ready, o_fifo_write, o_fifo_data, o_level, o_full, o_grant_id, o_busy
    );

endinterface

// File: rtl/cmd_queue_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or above ptr, wrapping around.
module rr_pick #(
    parameter  int N   = 2,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        // Outer loop walks priority order from ptr; inner loop maps it to a bit position.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && (j == (int'(ptr) + i) % N) && req[j]) begin
                    any           = 1'b1;
                    gnt_onehot[j] = 1'b1;
                    gnt_id        = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/cmd_queue_arbiter.sv
// Round-robin arbiter for the command FIFO write port with burst lock and a credit counter
// that blocks any write into a full FIFO.
module cmd_queue_arbiter
    import cmd_queue_arbiter_pkg::*;
#(
    parameter int NUM_REQ = CMDQ_NUM_REQ,
    parameter int DEPTH   = CMDQ_DEPTH
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    cmd_queue_arbiter_if.slave  bus,
    output arb_state_t          o_dbg_state
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int LW  = $clog2(DEPTH) + 1;

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [LW-1:0]      level_q, level_d;
    logic               fifo_write_q, fifo_write_d;
    cmd_t               fifo_data_q, fifo_data_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;
    logic               space;
    logic               pop;
    logic               accept;
    logic               sel_valid;
    logic [IDW-1:0]     sel_id;
    logic [NUM_REQ-1:0] ready;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req        (bus.i_req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_id     (pick_id),
        .any        (pick_any)
    );

    // The registered write still in flight already owns a FIFO slot.
    assign space   = ({1'b0, level_q} + (LW+1)'(fifo_write_q)) < (LW+1)'(DEPTH);
    assign pop     = bus.i_fifo_read && (level_q != '0);
    assign level_d = level_q + LW'(fifo_write_q) - LW'(pop);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        fifo_write_d = 1'b0;
        fifo_data_d  = fifo_data_q;
        sel_id       = pick_id;
        sel_valid    = pick_any;
        ready        = pick_onehot;

        if (state_q == BURST) begin
            sel_id         = owner_q;
            sel_valid      = bus.i_req_valid[owner_q];
            ready          = '0;
            ready[owner_q] = 1'b1;
        end

        if (!(space && i_rstn)) begin
            ready = '0;
        end

        accept = sel_valid && space && i_rstn;

        if (accept) begin
            fifo_write_d = 1'b1;
            fifo_data_d  = bus.i_req_data[sel_id];
            grant_d      = sel_id;
            if (bus.i_req_last[sel_id]) begin
                state_d  = IDLE;
                rr_ptr_d = IDW'(next_idx(int'(sel_id), NUM_REQ));
            end else begin
                state_d = BURST;
                owner_d = sel_id;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            level_q      <= '0;
            fifo_write_q <= 1'b0;
            fifo_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            level_q      <= level_d;
            fifo_write_q <= fifo_write_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    assign bus.o_req_ready  = ready;
    assign bus.o_fifo_write = fifo_write_q;
    assign bus.o_fifo_data  = fifo_data_q;
    assign bus.o_level      = level_q;
    assign bus.o_full       = (level_q == LW'(DEPTH));
    assign bus.o_grant_id   = grant_q;
    assign bus.o_busy       = (state_q == BURST) || fifo_write_q;
    assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_cmd_queue_arbiter.sv
// Directed bench for cmd_queue_arbiter: reset, round-robin contention, burst lock,
// full/credit return, simultaneous write+read, and reset in the middle of a burst.
module tb_cmd_queue_arbiter;
    import cmd_queue_arbiter_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cmd_queue_arbiter_if bus ();
    arb_state_t dbg_state;

    cmd_queue_arbiter dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic rd);
        bus.i_req_valid = v;
        bus.i_req_last  = l;
        bus.i_fifo_read = rd;
    endtask

    task automatic set_data(input int k);
        bus.i_req_data[0] = cmd_t'(16'h0100 + 16'(k));
        bus.i_req_data[1] = cmd_t'(16'h0200 + 16'(k));
    endtask

    initial begin
        // Reset held with every source requesting
        drive(2'b11, 2'b11, 1'b0);
        set_data(0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", 32'(bus.o_req_ready), 32'h0);
        check_eq("rst_write", 32'(bus.o_fifo_write), 32'h0);
        check_eq("rst_data", 32'(bus.o_fifo_data), 32'h0);
        check_eq("rst_level", 32'(bus.o_level), 32'h0);
        check_eq("rst_full", 32'(bus.o_full), 32'h0);
        check_eq("rst_grant", 32'(bus.o_grant_id), 32'h0);
        check_eq("rst_busy", 32'(bus.o_busy), 32'h0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));

        // Contention: alternating single-beat grants starting at source 0
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_data(k);
            drive(2'b11, 2'b11, 1'b0);
            #1;
            check_eq("cont_ready", 32'(bus.o_req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            @(negedge clk);
            check_eq("cont_write", 32'(bus.o_fifo_write), 32'h1);
            check_eq("cont_data", 32'(bus.o_fifo_data),
                     (k % 2 == 0) ? 32'(16'h0100 + 16'(k)) : 32'(16'h0200 + 16'(k)));
            check_eq("cont_grant", 32'(bus.o_grant_id), 32'(k % 2));
            if (k == 2) check_eq("cont_level", 32'(bus.o_level), 32'd2);
        end
        drive(2'b00, 2'b00, 1'b0);
        @(negedge clk);
        check_eq("cont_wr_end", 32'(bus.o_fifo_write), 32'h0);
        check_eq("cont_level6", 32'(bus.o_level), 32'd6);
        check_eq("cont_busy", 32'(bus.o_busy), 32'h0);

        // Drain past empty: reads at level 0 are ignored
        drive(2'b00, 2'b00, 1'b1);
        repeat (8) @(negedge clk);
        check_eq("rd_at_zero", 32'(bus.o_level), 32'd0);
        check_eq("rd_at_zero_full", 32'(bus.o_full), 32'h0);

        // Burst lock: source 1 owns the port for 3 beats, source 0 starved
        set_data(10);
        drive(2'b10, 2'b00, 1'b0);
        #1;
        check_eq("burst_b1_ready", 32'(bus.o_req_ready), 32'h2);
        @(negedge clk);
        check_eq("burst_b1_data", 32'(bus.o_fifo_data), 32'h020A);
        check_eq("burst_b1_grant", 32'(bus.o_grant_id), 32'h1);
        check_eq("burst_state", 32'(dbg_state), 32'(BURST));
        drive(2'b01, 2'b01, 1'b0);
        #1;
        check_eq("burst_starve", 32'(bus.o_req_ready[0]), 32'h0);
        @(negedge clk);
        check_eq("burst_gap_write", 32'(bus.o_fifo_write), 32'h0);
        check_eq("burst_gap_busy", 32'(bus.o_busy), 32'h1);
        set_data(11);
        drive(2'b11, 2'b01, 1'b0);
        #1;
        check_eq("burst_b2_ready", 32'(bus.o_req_ready), 32'h2);
        @(negedge clk);
        check_eq("burst_b2_data", 32'(bus.o_fifo_data), 32'h020B);
        set_data(12);
        drive(2'b11, 2'b11, 1'b0);
        #1;
        check_eq("burst_b3_ready", 32'(bus.o_req_ready), 32'h2);
        @(negedge clk);
        check_eq("burst_b3_data", 32'(bus.o_fifo_data), 32'h020C);
        check_eq("burst_end_state", 32'(dbg_state), 32'(IDLE));
        set_data(13);
        drive(2'b11, 2'b11, 1'b0);
        #1;
        check_eq("post_burst_ready", 32'(bus.o_req_ready), 32'h1);
        @(negedge clk);
        check_eq("post_burst_data", 32'(bus.o_fifo_data), 32'h010D);
        check_eq("post_burst_grant", 32'(bus.o_grant_id), 32'h0);
        drive(2'b00, 2'b00, 1'b0);
        @(negedge clk);
        check_eq("burst_level", 32'(bus.o_level), 32'd4);
        drive(2'b00, 2'b00, 1'b1);
        repeat (6) @(negedge clk);

        // Full: source 0 streams with no reads
        drive(2'b01, 2'b01, 1'b0);
        wr_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.o_fifo_write) wr_cnt++;
        end
        check_eq("full_writes", 32'(wr_cnt), 32'd16);
        check_eq("full_level", 32'(bus.o_level), 32'd16);
        check_eq("full_flag", 32'(bus.o_full), 32'h1);
        #1;
        check_eq("full_ready", 32'(bus.o_req_ready), 32'h0);
        drive(2'b01, 2'b01, 1'b1);
        #1;
        check_eq("full_read_same", 32'(bus.o_req_ready), 32'h0);
        @(negedge clk);
        drive(2'b01, 2'b01, 1'b0);
        #1;
        check_eq("full_credit_ready", 32'(bus.o_req_ready), 32'h1);
        check_eq("full_credit_level", 32'(bus.o_level), 32'd15);
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.o_fifo_write) wr_cnt++;
        end
        check_eq("refill_writes", 32'(wr_cnt), 32'd1);
        check_eq("refill_level", 32'(bus.o_level), 32'd16);

        // Simultaneous write and read at level 8
        drive(2'b00, 2'b00, 1'b1);
        repeat (8) @(negedge clk);
        check_eq("sim_pre_level", 32'(bus.o_level), 32'd8);
        set_data(30);
        drive(2'b01, 2'b01, 1'b0);
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b1);
        check_eq("sim_write", 32'(bus.o_fifo_write), 32'h1);
        check_eq("sim_mid_level", 32'(bus.o_level), 32'd8);
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b0);
        check_eq("sim_level", 32'(bus.o_level), 32'd8);

        // Reset after beat 2 of a 4-beat burst
        set_data(20);
        drive(2'b01, 2'b00, 1'b0);
        @(negedge clk);
        set_data(21);
        @(negedge clk);
        check_eq("mid_pre_write", 32'(bus.o_fifo_write), 32'h1);
        check_eq("mid_pre_state", 32'(dbg_state), 32'(BURST));
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_write", 32'(bus.o_fifo_write), 32'h0);
        check_eq("mid_rst_state", 32'(dbg_state), 32'(IDLE));
        check_eq("mid_rst_level", 32'(bus.o_level), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.o_req_ready), 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        drive(2'b00, 2'b00, 1'b0);
        @(negedge clk);
        check_eq("rel_write", 32'(bus.o_fifo_write), 32'h0);
        check_eq("rel_state", 32'(dbg_state), 32'(IDLE));
        check_eq("rel_busy", 32'(bus.o_busy), 32'h0);
        set_data(22);
        drive(2'b01, 2'b01, 1'b0);
        #1;
        check_eq("rel_ready", 32'(bus.o_req_ready), 32'h1);
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b0);
        check_eq("rel_data", 32'(bus.o_fifo_data), 32'h0116);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
